instr_fetch_unit: RTL and testbench

//  IF stage: owns the PC, issues reads to instruction memory/I-cache, applies branch/jump

---
 rtl/instr_fetch_unit_pkg.sv | 18 +
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: bubble encoding, reset PC
// default, FSM state encoding and the word-alignment helper.
package instr_fetch_unit_pkg;

  localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } if_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, requests instruction words, applies EX redirects and
// hazard stalls, and presents pc/instr/busywait to the IF/ID register.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_readdata,
  input  logic        imem_busywait,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        busywait_out
);

  if_state_e   state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] hold_instr, hold_nxt;
  logic [31:0] pend_pc, pend_nxt;
  logic [31:0] target_pc;
  logic [31:0] pc_plus4;
  logic        read_req;
  logic        done;

  assign target_pc = word_align(redirect_pc);
  assign pc_plus4  = pc + 32'd4;
  assign read_req  = (state != HOLD);
  assign done      = read_req & ~imem_busywait;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      hold_instr <= NOP_INSTR;
      pend_pc    <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      hold_instr <= hold_nxt;
      pend_pc    <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    hold_nxt     = hold_instr;
    pend_nxt     = pend_pc;
    instr_out    = NOP_INSTR;
    busywait_out = 1'b1;

    case (state)
      FETCH: begin
        if (redirect_en) begin
          busywait_out = 1'b0;
          if (done) begin
            pc_nxt = target_pc;
          end else begin
            // Memory cannot abort: park the target until the old request drains.
            pend_nxt  = target_pc;
            state_nxt = FLUSH;
          end
        end else if (stall) begin
          if (done) begin
            hold_nxt  = imem_readdata;
            state_nxt = HOLD;
          end
        end else if (done) begin
          pc_nxt       = pc_plus4;
          instr_out    = imem_readdata;
          busywait_out = 1'b0;
        end
      end

      HOLD: begin
        instr_out = hold_instr;
        if (redirect_en) begin
          pc_nxt       = target_pc;
          state_nxt    = FETCH;
          instr_out    = NOP_INSTR;
          busywait_out = 1'b0;
        end else if (!stall) begin
          pc_nxt       = pc_plus4;
          state_nxt    = FETCH;
          busywait_out = 1'b0;
        end
      end

      FLUSH: begin
        // The newest redirect always wins, even on the cycle the old word returns.
        if (redirect_en) begin
          pend_nxt = target_pc;
        end
        if (done) begin
          pc_nxt    = redirect_en ? target_pc : pend_pc;
          state_nxt = FETCH;
        end
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase

    if (rst) begin
      instr_out    = NOP_INSTR;
      busywait_out = 1'b1;
    end
  end

  assign imem_read = read_req | rst;
  assign imem_addr = pc;
  assign pc_out    = pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory responses and hazard inputs are
// driven by hand, every expectation is a hand-computed constant.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] imem_readdata;
  logic        imem_busywait;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        busywait_out;

  int vectors = 0;
  int errors  = 0;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .imem_read     (imem_read),
    .imem_addr     (imem_addr),
    .imem_readdata (imem_readdata),
    .imem_busywait (imem_busywait),
    .pc_out        (pc_out),
    .instr_out     (instr_out),
    .busywait_out  (busywait_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic busy, input logic [31:0] data);
    imem_busywait = busy;
    imem_readdata = data;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    mem(1'b0, 32'hA000_0000);
    #2;
    chk("rst_read", 32'(imem_read), 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_bw", 32'(busywait_out), 32'd1);
    rst = 1'b0;
    #1;

    // Zero-wait streaming: one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      mem(1'b0, 32'hA000_0000 + 32'(i));
      #1;
      chk("t1_pc", pc_out, 32'(4 * i));
      chk("t1_addr", imem_addr, 32'(4 * i));
      chk("t1_instr", instr_out, 32'hA000_0000 + 32'(i));
      chk("t1_bw", 32'(busywait_out), 32'd0);
      cyc();
    end

    // Two busy cycles then done, pc=16
    for (int i = 0; i < 2; i++) begin
      mem(1'b1, 32'hDEAD_0000);
      #1;
      chk("t2_bw_busy", 32'(busywait_out), 32'd1);
      chk("t2_addr", imem_addr, 32'h10);
      chk("t2_read", 32'(imem_read), 32'd1);
      cyc();
    end
    mem(1'b0, 32'hB000_0000);
    #1;
    chk("t2_bw_done", 32'(busywait_out), 32'd0);
    chk("t2_instr", instr_out, 32'hB000_0000);
    chk("t2_pc", pc_out, 32'h10);
    cyc();

    // Stall on a done fetch at pc=20, held for three cycles
    stall = 1'b1;
    mem(1'b0, 32'hC000_0000);
    #1;
    chk("t3_bw_stall", 32'(busywait_out), 32'd1);
    chk("t3_pc", pc_out, 32'h14);
    cyc();
    mem(1'b0, 32'hD000_0000);
    #1;
    chk("t3_hold_read", 32'(imem_read), 32'd0);
    chk("t3_hold_instr", instr_out, 32'hC000_0000);
    chk("t3_hold_bw", 32'(busywait_out), 32'd1);
    cyc();
    #1;
    chk("t3_hold2_instr", instr_out, 32'hC000_0000);
    cyc();
    stall = 1'b0;
    #1;
    chk("t3_rel_bw", 32'(busywait_out), 32'd0);
    chk("t3_rel_instr", instr_out, 32'hC000_0000);
    chk("t3_rel_pc", pc_out, 32'h14);
    cyc();
    mem(1'b0, 32'hE000_0000);
    #1;
    chk("t3_next_addr", imem_addr, 32'h18);
    chk("t3_next_instr", instr_out, 32'hE000_0000);
    cyc();

    // Redirect to 0x103 while fetch at 0x1C is busy
    redirect_en = 1'b1; redirect_pc = 32'h0000_0103;
    mem(1'b1, 32'hF000_0000);
    #1;
    chk("t4_redir_instr", instr_out, NOP);
    chk("t4_redir_bw", 32'(busywait_out), 32'd0);
    chk("t4_redir_addr", imem_addr, 32'h1C);
    cyc();
    redirect_en = 1'b0;
    #1;
    chk("t4_flush_bw", 32'(busywait_out), 32'd1);
    chk("t4_flush_addr", imem_addr, 32'h1C);
    chk("t4_flush_read", 32'(imem_read), 32'd1);
    cyc();
    mem(1'b0, 32'hF000_0000);
    #1;
    chk("t4_drain_instr", instr_out, NOP);
    chk("t4_drain_bw", 32'(busywait_out), 32'd1);
    cyc();
    mem(1'b0, 32'h1111_1111);
    #1;
    chk("t4_tgt_addr", imem_addr, 32'h100);
    chk("t4_tgt_pc", pc_out, 32'h100);
    chk("t4_tgt_instr", instr_out, 32'h1111_1111);
    cyc();

    // Redirect and stall together while in HOLD
    stall = 1'b1;
    mem(1'b0, 32'h2222_2222);
    #1;
    cyc();
    redirect_en = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    chk("t5_instr", instr_out, NOP);
    chk("t5_bw", 32'(busywait_out), 32'd0);
    cyc();
    redirect_en = 1'b0; stall = 1'b0;
    mem(1'b0, 32'h3333_3333);
    #1;
    chk("t5_pc", pc_out, 32'h200);
    chk("t5_read", 32'(imem_read), 32'd1);
    chk("t5_instr2", instr_out, 32'h3333_3333);
    cyc();

    // Newer redirect coincident with the draining done in FLUSH
    redirect_en = 1'b1; redirect_pc = 32'h0000_0300;
    mem(1'b1, 32'h0);
    #1;
    cyc();
    redirect_pc = 32'h0000_0401;
    mem(1'b0, 32'h4444_0000);
    #1;
    chk("t5b_flush_instr", instr_out, NOP);
    cyc();
    redirect_en = 1'b0;
    #1;
    chk("t5b_pc", pc_out, 32'h400);

    // Asynchronous reset in the middle of FLUSH
    redirect_en = 1'b1; redirect_pc = 32'h0000_0500;
    mem(1'b1, 32'h0);
    cyc();
    redirect_en = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_pc", pc_out, 32'h0);
    chk("t6_rst_addr", imem_addr, 32'h0);
    chk("t6_rst_instr", instr_out, NOP);
    chk("t6_rst_bw", 32'(busywait_out), 32'd1);
    rst = 1'b0;
    mem(1'b0, 32'h5555_5555);
    #1;
    chk("t6_post_instr", instr_out, 32'h5555_5555);
    chk("t6_post_bw", 32'(busywait_out), 32'd0);
    cyc();

    // Wrap at the top of the address space; redirect_pc low bits forced clear
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    mem(1'b0, 32'h0);
    cyc();
    redirect_en = 1'b0;
    mem(1'b0, 32'h6666_6666);
    #1;
    chk("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
    chk("t6_top_instr", instr_out, 32'h6666_6666);
    cyc();
    #1;
    chk("t6_wrap_pc", pc_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
